// File: rtl/ndp_tile_sequencer.sv
// Sequencer for one NDP_unit tile operation: buffers K operand beats, clears the
// array, streams the beats back-to-back, then hands the captured result tile out.
module ndp_tile_sequencer #(
    parameter  int WIDTH      = 16,
    parameter  int ARR_HEIGHT = 4,
    parameter  int ARR_WIDTH  = 4,
    parameter  int SYS_HEIGHT = 1,
    parameter  int SYS_WIDTH  = 64,
    parameter  int K_MAX      = 16,
    parameter  int TIMEOUT    = 1023,
    localparam int AW = SYS_HEIGHT * ARR_HEIGHT * WIDTH,
    localparam int BW = SYS_WIDTH * ARR_WIDTH * WIDTH,
    localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH,
    localparam int KW = $clog2(K_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [AW-1:0] op_a,
    input  logic [BW-1:0] op_b,
    output logic          arr_reset,
    output logic [AW-1:0] arr_in_a,
    output logic [BW-1:0] arr_in_b,
    output logic          arr_in_done_flag,
    input  logic          arr_calc_done_flag,
    input  logic [CW-1:0] arr_out_c,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_data,
    output logic          busy,
    output logic          err_cmd,
    output logic          err_timeout
);
    localparam int IW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [KW-1:0]        cnt_r, cnt_s;
    logic [KW-1:0]        k_r, k_s;
    logic [TW-1:0]        timer_r, timer_s;
    logic [AW+BW-1:0]     op_buf_r [K_MAX];
    logic [AW+BW-1:0]     beat_s;

    logic                 cmd_fire_s, cmd_legal_s, capture_s, timeout_hit_s;
    logic                 arr_reset_s, in_done_s, res_valid_s, err_cmd_s, err_timeout_s;
    logic [AW-1:0]        arr_in_a_s;
    logic [BW-1:0]        arr_in_b_s;
    logic [CW-1:0]        res_data_s;

    assign cmd_ready     = (state_r == S_IDLE);
    assign op_ready      = (state_r == S_LOAD);
    assign busy          = (state_r != S_IDLE);
    assign cmd_fire_s    = (state_r == S_IDLE) && cmd_valid;
    assign cmd_legal_s   = (cmd_k != KW'(0)) && (cmd_k <= KW'(K_MAX));
    assign capture_s     = (state_r == S_WAIT) && arr_calc_done_flag;
    assign timeout_hit_s = (state_r == S_WAIT) && !arr_calc_done_flag &&
                           (timer_r == TW'(TIMEOUT - 1));

    // State, beat counter, latched K and WAIT timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            k_r     <= '0;
            timer_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            k_r     <= k_s;
            timer_r <= timer_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        k_s     = k_r;
        timer_s = timer_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_fire_s && cmd_legal_s) begin
                    state_s = S_LOAD;
                    k_s     = cmd_k;
                    cnt_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (op_valid && (cnt_r == k_r - KW'(1))) begin
                    state_s = S_CLEAR;
                    cnt_s   = '0;
                end else if (op_valid) begin
                    cnt_s = cnt_r + KW'(1);
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_CLEAR: begin
                state_s = S_STREAM;
                cnt_s   = '0;
            end
            S_STREAM: begin
                if (cnt_r == k_r - KW'(1)) begin
                    state_s = S_WAIT;
                    cnt_s   = '0;
                    timer_s = '0;
                end else begin
                    cnt_s = cnt_r + KW'(1);
                end
            end
            S_WAIT: begin
                if (capture_s) begin
                    state_s = S_RESULT;
                end else if (timeout_hit_s) begin
                    state_s = S_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESULT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Operand buffer; contents are don't-care outside LOAD/STREAM
    always_ff @(posedge clk) begin
        if (state_r == S_LOAD && op_valid) begin
            op_buf_r[cnt_r[IW-1:0]] <= {op_a, op_b};
        end
    end

    // Registered outputs are computed from the upcoming state so they line up with it
    always_comb begin
        arr_reset_s   = 1'b1;
        arr_in_a_s    = '0;
        arr_in_b_s    = '0;
        in_done_s     = 1'b0;
        res_valid_s   = 1'b0;
        res_data_s    = res_data;
        err_cmd_s     = 1'b0;
        err_timeout_s = err_timeout;
        beat_s        = op_buf_r[cnt_s[IW-1:0]];
        case (state_s)
            S_STREAM: begin
                arr_reset_s = 1'b0;
                arr_in_a_s  = beat_s[AW+BW-1:BW];
                arr_in_b_s  = beat_s[BW-1:0];
            end
            S_WAIT: begin
                arr_reset_s = 1'b0;
                in_done_s   = 1'b1;
            end
            S_RESULT: begin
                arr_reset_s = 1'b0;
                res_valid_s = 1'b1;
            end
            default: begin
                arr_reset_s = 1'b1;
            end
        endcase
        if (capture_s) begin
            res_data_s = arr_out_c;
        end else begin
            res_data_s = res_data;
        end
        if (cmd_fire_s && !cmd_legal_s) begin
            err_cmd_s = 1'b1;
        end else begin
            err_cmd_s = 1'b0;
        end
        if (cmd_fire_s && cmd_legal_s) begin
            err_timeout_s = 1'b0;
        end else if (timeout_hit_s) begin
            err_timeout_s = 1'b1;
        end else begin
            err_timeout_s = err_timeout;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            arr_reset        <= 1'b1;
            arr_in_a         <= '0;
            arr_in_b         <= '0;
            arr_in_done_flag <= 1'b0;
            res_valid        <= 1'b0;
            res_data         <= '0;
            err_cmd          <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            arr_reset        <= arr_reset_s;
            arr_in_a         <= arr_in_a_s;
            arr_in_b         <= arr_in_b_s;
            arr_in_done_flag <= in_done_s;
            res_valid        <= res_valid_s;
            res_data         <= res_data_s;
            err_cmd          <= err_cmd_s;
            err_timeout      <= err_timeout_s;
        end
    end

endmodule

// File: doc/ndp_tile_sequencer.md
Name: ndp_tile_sequencer

Overview:
- Controller that sequences one NDP_unit systolic-array tile operation: accepts a command, buffers K operand beats (A column plus B row per beat), clears the array, then streams the beats on consecutive cycles.
- It then raises in_done_flag, waits for calc_done_flag, captures out_c and hands the result tile to the requester over a valid/ready port.
- Sits between the NDP operand fetch logic and the NDP_unit instance. It is the only driver of the array's reset, in_a, in_b and in_done_flag.

Parameters:
- WIDTH, 16, element width.
- ARR_HEIGHT, 4, PE rows per systolic array.
- ARR_WIDTH, 4, PE columns per systolic array.
- SYS_HEIGHT, 1, arrays stacked vertically.
- SYS_WIDTH, 64, arrays side by side.
- K_MAX, 16, maximum inner dimension (operand buffer depth).
- TIMEOUT, 1023, maximum cycles to wait for calc_done_flag.
- Derived widths: AW = SYS_HEIGHT*ARR_HEIGHT*WIDTH; BW = SYS_WIDTH*ARR_WIDTH*WIDTH; CW = SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH; KW = $clog2(K_MAX+1).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_k  in  KW  inner dimension K; legal range 1..K_MAX.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  high only in LOAD.
- op_a  in  AW  A column for this beat.
- op_b  in  BW  B row for this beat.
- arr_reset  out  1  to NDP_unit reset.
- arr_in_a  out  AW  to NDP_unit in_a.
- arr_in_b  out  BW  to NDP_unit in_b.
- arr_in_done_flag  out  1  to NDP_unit in_done_flag.
- arr_calc_done_flag  in  1  from NDP_unit calc_done_flag.
- arr_out_c  in  CW  from NDP_unit out_c.
- res_valid  out  1  result tile valid.
- res_ready  in  1  result consumer ready.
- res_data  out  CW  captured result tile.
- busy  out  1  state != IDLE.
- err_cmd  out  1  one-cycle pulse when an illegal cmd_k is consumed.
- err_timeout  out  1  sticky; cleared on the next accepted legal command.

Behaviour:
- Reset values (while reset is high and on the cycle after): state IDLE, arr_reset=1, all other outputs 0 except cmd_ready=1 from the first cycle after reset. Counters 0, buffer contents don't-care.
- All outputs are registered, except cmd_ready, op_ready and busy, which are decoded from the state register.

IDLE:
- If cmd_valid is high and cmd_k is in 1..K_MAX: latch k, clear err_timeout, go to LOAD.
- If cmd_valid is high and cmd_k is 0 or greater than K_MAX: consume the command, pulse err_cmd for 1 cycle, stay in IDLE.
- arr_reset holds at 1 throughout IDLE.

LOAD:
- Each op_valid&&op_ready cycle writes buf[cnt] and increments cnt. Gaps in op_valid are allowed.
- After beat k-1 is accepted: cnt=0, go to CLEAR.

CLEAR:
- 1 cycle. arr_reset=1, arr_in_* = 0. Go to STREAM.

STREAM:
- Exactly k consecutive cycles, with no stalls.
- Cycle i drives arr_reset=0, arr_in_a=buf[i].a, arr_in_b=buf[i].b, arr_in_done_flag=0.
- After cycle k-1, go to WAIT.
- arr_calc_done_flag is ignored in this state.

WAIT:
- arr_in_done_flag=1 and arr_in_* = 0. The flag holds until the done flag is seen; the timer increments each cycle.
- On arr_calc_done_flag=1: res_data <= arr_out_c in that cycle, res_valid=1 on the next cycle, drop arr_in_done_flag, go to RESULT.
- If the timer reaches TIMEOUT without the done flag: set err_timeout, arr_reset=1, go to IDLE, no result.

RESULT:
- res_valid and res_data are held stable until res_valid&&res_ready.
- In the handshake cycle: res_valid=0 next cycle, arr_reset=1, go to IDLE.
- res_ready high before res_valid has no effect.

Latency and rules:
- With gap-free operands: the command is accepted at cycle T, load beats occupy T+1..T+k, CLEAR is T+k+1, and STREAM is T+k+2..T+2k+1.
- arr_in_done_flag first rises at T+2k+2.
- cmd_valid while busy is ignored (cmd_ready=0). op_valid outside LOAD is ignored.
- Reset asserted in any state aborts the operation: buffer discarded, res_valid drops, the pending result is lost, and the block returns to IDLE.

Test Plan:
- Reset, then cmd_k=3 with 3 gap-free beats taken from test vector set 0. Required: arr_reset low exactly 3 STREAM cycles after the 1-cycle CLEAR; arr_in_a/arr_in_b equal beats 0, 1, 2 in order; arr_in_done_flag=1 from T+8; res_data equals the expected A@B tile; res_valid held until res_ready.
- cmd_k=16 with op_valid toggling every other cycle. Required: LOAD spans 32 cycles, STREAM still presents 16 back-to-back beats, and the result is correct.
- cmd_k=0, then cmd_k=17. Required: each gives a single err_cmd pulse, stays in IDLE, op_ready stays 0. A following cmd_k=2 completes normally.
- Model holds arr_calc_done_flag low. Required: err_timeout set after exactly 1023 WAIT cycles, return to IDLE with no res_valid. The next legal command clears err_timeout.
- Assert reset for 1 cycle in the middle of STREAM (beat 1 of 3). Required: next cycle is IDLE, arr_reset=1, arr_in_done_flag=0, res_valid=0.
- res_ready held low for 20 cycles in RESULT while cmd_valid pulses. Required: res_data is stable, the command is not accepted, and the command is accepted in the cycle after the result handshake.
